// File: rtl/trigger_sequencer_if.sv
// Handshake/data bundle between the ADC capture side, the trigger sequencer and the framer.
// The slave modport is the sequencer's view; master is the driving/observing side.
interface trigger_sequencer_if #(
   parameter int DATA_WIDTH           = 128,
   parameter int ADC_RESOLUTION_WIDTH = 12,
   parameter int TIME_STAMP_WIDTH     = 48,
   parameter int MAX_DELAY_CNT_WIDTH  = 5,
   parameter int MAX_TRIG_LEN_WIDTH   = 8,
   parameter int HOLDOFF_WIDTH        = 8
);
   logic                            ENABLE;
   logic                            DIN_VALID;
   logic [DATA_WIDTH-1:0]           DIN;
   logic [ADC_RESOLUTION_WIDTH:0]   THRESHOLD;
   logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE;
   logic [MAX_DELAY_CNT_WIDTH-1:0]  DELAY_CFG;
   logic [MAX_TRIG_LEN_WIDTH-1:0]   MAX_TRIG_LEN;
   logic [HOLDOFF_WIDTH-1:0]        HOLDOFF_LEN;
   logic                            TRIGGERED;
   logic [MAX_DELAY_CNT_WIDTH-1:0]  DELAY;
   logic [TIME_STAMP_WIDTH-1:0]     TIME_STAMP;
   logic [ADC_RESOLUTION_WIDTH:0]   THRESHOLD_WHEN_HIT;
   logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE_WHEN_HIT;
   logic                            ARMED;
   logic [31:0]                     FRAME_COUNT;

   modport master (
      output ENABLE, DIN_VALID, DIN, THRESHOLD, BASELINE, DELAY_CFG, MAX_TRIG_LEN, HOLDOFF_LEN,
      input  TRIGGERED, DELAY, TIME_STAMP, THRESHOLD_WHEN_HIT, BASELINE_WHEN_HIT, ARMED, FRAME_COUNT
   );

   modport slave (
      input  ENABLE, DIN_VALID, DIN, THRESHOLD, BASELINE, DELAY_CFG, MAX_TRIG_LEN, HOLDOFF_LEN,
      output TRIGGERED, DELAY, TIME_STAMP, THRESHOLD_WHEN_HIT, BASELINE_WHEN_HIT, ARMED, FRAME_COUNT
   );
endinterface

// File: rtl/trigger_sequencer.sv
// Per-channel trigger controller: arms on ENABLE, opens a frame when any lane reaches BASELINE+THRESHOLD,
// caps frame length and holds off re-arming long enough for the framer's footer to precede the next header.
module trigger_sequencer #(
   parameter int DATA_WIDTH           = 128,
   parameter int ADC_RESOLUTION_WIDTH = 12,
   parameter int TIME_STAMP_WIDTH     = 48,
   parameter int MAX_DELAY_CNT_WIDTH  = 5,
   parameter int MAX_TRIG_LEN_WIDTH   = 8,
   parameter int HOLDOFF_WIDTH        = 8
) (
   input  logic               CLK,
   input  logic               RESETN,
   trigger_sequencer_if.slave bus
);
   localparam int LANES = DATA_WIDTH / 16;
   localparam int LW    = ADC_RESOLUTION_WIDTH + 2;
   localparam int HCW   = HOLDOFF_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRIG, S_HOLDOFF} state_t;

   state_t                            state_q, state_d;
   logic [TIME_STAMP_WIDTH-1:0]       ts_q;
   logic [ADC_RESOLUTION_WIDTH:0]     thr_q;
   logic [ADC_RESOLUTION_WIDTH-1:0]   base_q;
   logic [MAX_DELAY_CNT_WIDTH-1:0]    dly_q;
   logic [MAX_TRIG_LEN_WIDTH-1:0]     mtl_q;
   logic [HOLDOFF_WIDTH-1:0]          hol_q;
   logic [MAX_TRIG_LEN_WIDTH-1:0]     len_q, len_d;
   logic [HCW-1:0]                    hcnt_q, hcnt_d;
   logic [TIME_STAMP_WIDTH-1:0]       tsnap_q;
   logic [ADC_RESOLUTION_WIDTH:0]     thr_hit_q;
   logic [ADC_RESOLUTION_WIDTH-1:0]   base_hit_q;
   logic [31:0]                       fcnt_q;
   logic                              start;
   logic                              hit;
   logic [LW-1:0]                     level;
   logic [HCW-1:0]                    dly_plus2, hol_ext, eff;
   logic                              unused_din;

   // Lane bits above the sample field carry no information here.
   assign unused_din = ^bus.DIN;

   assign level = LW'(base_q) + LW'(thr_q);

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (LW'(bus.DIN[i*16 +: ADC_RESOLUTION_WIDTH]) >= level) hit = 1'b1;
      end
      hit = hit & bus.DIN_VALID;
   end

   // Holdoff never shorter than the framer's footer delay, so frames cannot overlap.
   assign dly_plus2 = HCW'(dly_q) + HCW'(2);
   assign hol_ext   = HCW'(hol_q);
   assign eff       = (hol_ext > dly_plus2) ? hol_ext : dly_plus2;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      hcnt_d  = hcnt_q;
      start   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.ENABLE) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (!bus.ENABLE) begin
               state_d = S_IDLE;
            end else if (hit) begin
               state_d = S_TRIG;
               len_d   = MAX_TRIG_LEN_WIDTH'(1);
               start   = 1'b1;
            end
         end
         S_TRIG: begin
            if (bus.DIN_VALID) begin
               if (!hit || ((mtl_q != '0) && (len_q == mtl_q))) begin
                  state_d = S_HOLDOFF;
                  hcnt_d  = eff;
               end else if (len_q != {MAX_TRIG_LEN_WIDTH{1'b1}}) begin
                  len_d = len_q + 1'b1;
               end
            end
         end
         S_HOLDOFF: begin
            if (hcnt_q <= HCW'(1)) begin
               state_d = bus.ENABLE ? S_ARMED : S_IDLE;
               hcnt_d  = '0;
            end else begin
               hcnt_d = hcnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q    <= S_IDLE;
         ts_q       <= '0;
         thr_q      <= '0;
         base_q     <= '0;
         dly_q      <= '0;
         mtl_q      <= '0;
         hol_q      <= '0;
         len_q      <= '0;
         hcnt_q     <= '0;
         tsnap_q    <= '0;
         thr_hit_q  <= '0;
         base_hit_q <= '0;
         fcnt_q     <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         hcnt_q  <= hcnt_d;
         ts_q    <= ts_q + 1'b1;
         // Config is frozen for the duration of a frame.
         if (state_q != S_TRIG) begin
            thr_q  <= bus.THRESHOLD;
            base_q <= bus.BASELINE;
            dly_q  <= bus.DELAY_CFG;
            mtl_q  <= bus.MAX_TRIG_LEN;
            hol_q  <= bus.HOLDOFF_LEN;
         end
         if (start) begin
            tsnap_q    <= ts_q;
            thr_hit_q  <= thr_q;
            base_hit_q <= base_q;
            fcnt_q     <= fcnt_q + 32'd1;
         end
      end
   end

   assign bus.TRIGGERED          = (state_q == S_TRIG);
   assign bus.ARMED              = (state_q == S_ARMED);
   assign bus.DELAY              = dly_q;
   assign bus.TIME_STAMP         = tsnap_q;
   assign bus.THRESHOLD_WHEN_HIT = thr_hit_q;
   assign bus.BASELINE_WHEN_HIT  = base_hit_q;
   assign bus.FRAME_COUNT        = fcnt_q;
endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed and randomized bench for trigger_sequencer against a cycle-level behavioural model.
module tb_trigger_sequencer;
   localparam int M_IDLE = 0, M_ARMED = 1, M_TRIG = 2, M_HOLD = 3;
   localparam longint TS_MASK = (64'd1 << 48) - 1;

   logic CLK = 1'b0;
   logic RESETN = 1'b0;
   int   n_checks = 0;
   int   n_err = 0;

   trigger_sequencer_if bus ();
   trigger_sequencer dut (.CLK(CLK), .RESETN(RESETN), .bus(bus));

   always #5 CLK = ~CLK;

   // Behavioural model: mode, counters and snapshots as plain integers.
   int          m_mode, m_len, m_hold;
   longint      m_ts, e_ts;
   int          sh_thr, sh_base, sh_dly, sh_mtl, sh_hol;
   int          e_thr, e_base;
   int unsigned e_fc;

   task automatic m_reset();
      m_mode = M_IDLE; m_len = 0; m_hold = 0; m_ts = 0; e_ts = 0;
      sh_thr = 0; sh_base = 0; sh_dly = 0; sh_mtl = 0; sh_hol = 0;
      e_thr = 0; e_base = 0; e_fc = 0;
   endtask

   function automatic int lane_max(input logic [127:0] d);
      int m, s;
      m = 0;
      for (int i = 0; i < 8; i++) begin
         s = int'(d[i*16 +: 12]);
         if (s > m) m = s;
      end
      return m;
   endfunction

   task automatic model_eval();
      int  n_mode;
      bit  hit;
      hit    = bus.DIN_VALID && (lane_max(bus.DIN) >= sh_base + sh_thr);
      n_mode = m_mode;
      case (m_mode)
         M_IDLE:  if (bus.ENABLE) n_mode = M_ARMED;
         M_ARMED: begin
            if (!bus.ENABLE) n_mode = M_IDLE;
            else if (hit) begin
               n_mode = M_TRIG; m_len = 1;
               e_ts = m_ts; e_thr = sh_thr; e_base = sh_base; e_fc = e_fc + 1;
            end
         end
         M_TRIG: begin
            if (bus.DIN_VALID) begin
               if (!hit || (sh_mtl != 0 && m_len >= sh_mtl)) begin
                  n_mode = M_HOLD;
                  m_hold = (sh_hol > sh_dly + 2) ? sh_hol : sh_dly + 2;
               end else if (m_len < 255) m_len++;
            end
         end
         default: begin
            m_hold--;
            if (m_hold == 0) n_mode = bus.ENABLE ? M_ARMED : M_IDLE;
         end
      endcase
      if (m_mode != M_TRIG) begin
         sh_thr = int'(bus.THRESHOLD); sh_base = int'(bus.BASELINE); sh_dly = int'(bus.DELAY_CFG);
         sh_mtl = int'(bus.MAX_TRIG_LEN); sh_hol = int'(bus.HOLDOFF_LEN);
      end
      m_mode = n_mode;
      m_ts   = (m_ts + 1) & TS_MASK;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".TRIGGERED"}, 64'(bus.TRIGGERED), 64'(m_mode == M_TRIG));
      chk({tag, ".ARMED"}, 64'(bus.ARMED), 64'(m_mode == M_ARMED));
      chk({tag, ".DELAY"}, 64'(bus.DELAY), 64'(sh_dly));
      chk({tag, ".TIME_STAMP"}, 64'(bus.TIME_STAMP), 64'(e_ts));
      chk({tag, ".THR_HIT"}, 64'(bus.THRESHOLD_WHEN_HIT), 64'(e_thr));
      chk({tag, ".BASE_HIT"}, 64'(bus.BASELINE_WHEN_HIT), 64'(e_base));
      chk({tag, ".FRAME_COUNT"}, 64'(bus.FRAME_COUNT), 64'(e_fc));
   endtask

   task automatic step(input string tag);
      model_eval();
      @(posedge CLK);
      #1;
      check_all(tag);
   endtask

   task automatic set_cfg(input int base, input int thr, input int dly, input int mtl, input int hol);
      bus.BASELINE = 12'(base); bus.THRESHOLD = 13'(thr); bus.DELAY_CFG = 5'(dly);
      bus.MAX_TRIG_LEN = 8'(mtl); bus.HOLDOFF_LEN = 8'(hol);
   endtask

   function automatic logic [127:0] lane_val(input int lane, input int val);
      logic [127:0] d;
      d = '0;
      d[lane*16 +: 16] = 16'(val);
      return d;
   endfunction

   function automatic logic [127:0] fill(input int val);
      logic [127:0] d;
      for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(val);
      return d;
   endfunction

   task automatic wait_armed(input string tag);
      for (int i = 0; i < 300 && !bus.ARMED; i++) step(tag);
      chk({tag, ".armed_reached"}, 64'(bus.ARMED), 64'd1);
   endtask

   task automatic wait_trig(input string tag);
      for (int i = 0; i < 300 && !bus.TRIGGERED; i++) step(tag);
      chk({tag, ".trig_reached"}, 64'(bus.TRIGGERED), 64'd1);
   endtask

   // Quiet input, re-arm, then load a new configuration into the shadow registers.
   task automatic rearm(input string tag, input int base, input int thr, input int dly,
                        input int mtl, input int hol);
      bus.DIN = '0; bus.DIN_VALID = 1'b1; bus.ENABLE = 1'b1;
      wait_armed(tag);
      set_cfg(base, thr, dly, mtl, hol);
      step(tag); step(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      bit  seen;
      bus.ENABLE = 1'b0; bus.DIN_VALID = 1'b0; bus.DIN = '0;
      set_cfg(0, 0, 0, 0, 0);
      m_reset();
      @(posedge CLK); #1;
      check_all("reset");
      RESETN = 1'b1;

      // First trigger at timestamp 20 on lane 3.
      set_cfg(100, 50, 3, 0, 0);
      bus.ENABLE = 1'b1; bus.DIN_VALID = 1'b1;
      for (int i = 0; i < 100 && m_ts != 20; i++) step("pre20");
      bus.DIN = lane_val(3, 150);
      step("hit20");
      chk("first.TRIGGERED", 64'(bus.TRIGGERED), 64'd1);
      chk("first.TIME_STAMP", 64'(bus.TIME_STAMP), 64'd20);
      chk("first.THR_HIT", 64'(bus.THRESHOLD_WHEN_HIT), 64'd50);
      chk("first.BASE_HIT", 64'(bus.BASELINE_WHEN_HIT), 64'd100);
      chk("first.FRAME_COUNT", 64'(bus.FRAME_COUNT), 64'd1);
      bus.DIN = '0;

      // Threshold boundary.
      wait_armed("b149");
      bus.DIN = fill(149);
      for (int i = 0; i < 6; i++) step("b149");
      chk("below_level.TRIGGERED", 64'(bus.TRIGGERED), 64'd0);
      bus.DIN = lane_val(0, 150);
      step("b150");
      chk("at_level.TRIGGERED", 64'(bus.TRIGGERED), 64'd1);

      // Level computed without wrap; upper lane bits ignored.
      rearm("nowrap", 4095, 4095, 0, 0, 0);
      bus.DIN = fill(16'hFFFF);
      for (int i = 0; i < 10; i++) step("nowrap");
      chk("nowrap.TRIGGERED", 64'(bus.TRIGGERED), 64'd0);
      chk("nowrap.ARMED", 64'(bus.ARMED), 64'd1);

      // Max frame length with continuous hit.
      rearm("mtl", 100, 50, 3, 4, 0);
      bus.DIN = lane_val(5, 200);
      wait_trig("mtl");
      cnt = 0;
      for (int i = 0; i < 40 && bus.TRIGGERED; i++) begin cnt++; step("mtl"); end
      chk("maxlen_cont.valid_cycles", 64'(cnt), 64'd4);

      // Max frame length with valid gaps.
      rearm("mtlgap", 100, 50, 3, 4, 0);
      bus.DIN = lane_val(7, 300);
      wait_trig("mtlgap");
      cnt = 0;
      for (int i = 0; i < 60 && bus.TRIGGERED; i++) begin
         bus.DIN_VALID = ($urandom_range(0, 1) == 1);
         if (bus.DIN_VALID) cnt++;
         step("mtlgap");
      end
      bus.DIN_VALID = 1'b1;
      chk("maxlen_gaps.valid_cycles", 64'(cnt), 64'd4);

      // Holdoff floor from DELAY and explicit holdoff, with hit held throughout.
      for (int k = 0; k < 2; k++) begin
         rearm("hold", 100, 50, 6, 1, (k == 0) ? 2 : 20);
         bus.DIN = lane_val(2, 400);
         wait_trig("hold");
         step("hold");
         cnt = 0; seen = 1'b0;
         for (int i = 0; i < 100 && !bus.ARMED; i++) begin
            cnt++;
            step("hold");
            if (bus.TRIGGERED) seen = 1'b1;
         end
         chk((k == 0) ? "holdoff_delay.cycles" : "holdoff_len.cycles", 64'(cnt), (k == 0) ? 64'd8 : 64'd20);
         chk("holdoff.hit_ignored", 64'(seen), 64'd0);
      end

      // ENABLE drop and THRESHOLD change mid-frame.
      rearm("endrop", 100, 50, 2, 0, 3);
      bus.DIN = lane_val(1, 160);
      wait_trig("endrop");
      bus.ENABLE = 1'b0; bus.THRESHOLD = 13'd4000;
      for (int i = 0; i < 3; i++) step("endrop");
      chk("thr_change.TRIGGERED", 64'(bus.TRIGGERED), 64'd1);
      chk("thr_change.THR_HIT", 64'(bus.THRESHOLD_WHEN_HIT), 64'd50);
      bus.DIN = '0;
      for (int i = 0; i < 10; i++) step("endrop");
      chk("endrop.ARMED", 64'(bus.ARMED), 64'd0);
      chk("endrop.TRIGGERED", 64'(bus.TRIGGERED), 64'd0);

      // Asynchronous reset mid-frame, then timestamp restart.
      rearm("arst", 100, 50, 4, 0, 0);
      bus.DIN = lane_val(4, 150);
      wait_trig("arst");
      RESETN = 1'b0;
      m_reset();
      #1;
      chk("arst.TRIGGERED", 64'(bus.TRIGGERED), 64'd0);
      check_all("arst");
      RESETN = 1'b1;
      step("restart");
      step("restart");
      chk("restart.TIME_STAMP", 64'(bus.TIME_STAMP), 64'd1);
      chk("restart.FRAME_COUNT", 64'(bus.FRAME_COUNT), 64'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if (i % 40 == 0)
            set_cfg($urandom_range(50, 200), $urandom_range(0, 150), $urandom_range(0, 31),
                    $urandom_range(0, 8), $urandom_range(0, 12));
         bus.ENABLE    = ($urandom_range(0, 15) != 0);
         bus.DIN_VALID = ($urandom_range(0, 3) != 0);
         for (int l = 0; l < 8; l++)
            bus.DIN[l*16 +: 16] = {4'($urandom), 12'($urandom_range(0, 330))};
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- Per-channel trigger controller that sequences the header/footer framing stage (add_header_footer).
- Watches the packed ADC sample stream and drives TRIGGERED, the hit-time timestamp snapshot, the threshold/baseline snapshot and the DELAY value into the framer.
- Enforces maximum frame length and a minimum re-arm spacing so that a footer is always emitted before the next header.
- Sits between the ADC capture/baseline logic and the framer, one instance per channel.

Parameters:
DATA_WIDTH, 128, stream width; 8 lanes of 16 bits, sample in lane[ADC_RESOLUTION_WIDTH-1:0], unsigned
ADC_RESOLUTION_WIDTH, 12, sample width
TIME_STAMP_WIDTH, 48, free-running timestamp counter width
MAX_DELAY_CNT_WIDTH, 5, width of DELAY
MAX_TRIG_LEN_WIDTH, 8, width of MAX_TRIG_LEN and frame-length counter
HOLDOFF_WIDTH, 8, width of HOLDOFF_LEN and holdoff counter

Ports:
CLK  in  1  clock
RESETN  in  1  reset; asynchronous, active-low
ENABLE  in  1  arm request
DIN_VALID  in  1  DIN qualifier
DIN  in  DATA_WIDTH  packed samples
THRESHOLD  in  ADC_RESOLUTION_WIDTH+1  offset above baseline
BASELINE  in  ADC_RESOLUTION_WIDTH  current baseline
DELAY_CFG  in  MAX_DELAY_CNT_WIDTH  framer pre-trigger delay
MAX_TRIG_LEN  in  MAX_TRIG_LEN_WIDTH  max TRIGGERED valid-cycles; 0 = unlimited
HOLDOFF_LEN  in  HOLDOFF_WIDTH  requested re-arm spacing in cycles
TRIGGERED  out  1  to framer
DELAY  out  MAX_DELAY_CNT_WIDTH  to framer
TIME_STAMP  out  TIME_STAMP_WIDTH  timestamp snapshot at trigger start
THRESHOLD_WHEN_HIT  out  ADC_RESOLUTION_WIDTH+1  snapshot
BASELINE_WHEN_HIT  out  ADC_RESOLUTION_WIDTH  snapshot
ARMED  out  1  high in ARMED state
FRAME_COUNT  out  32  frames started, wraps

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; timestamp counter 0; length and holdoff counters 0.
- Timestamp counter: increments every clock from reset and wraps at 2^TIME_STAMP_WIDTH.
- Shadow config: THRESHOLD, BASELINE, DELAY_CFG, MAX_TRIG_LEN and HOLDOFF_LEN are registered every cycle in IDLE/ARMED/HOLDOFF and frozen in TRIG. DELAY output = shadow DELAY_CFG.
- Level: level = BASELINE + THRESHOLD, computed at ADC_RESOLUTION_WIDTH+2 bits with no saturation.
- Hit: DIN_VALID and any lane sample (zero-extended) >= level.
- IDLE: ENABLE=1 -> ARMED next cycle.
- ARMED: ENABLE=0 -> IDLE. Otherwise a hit on cycle t moves to TRIG; in the same edge:
  - TRIGGERED=1 from t+1 (one-cycle latency);
  - TIME_STAMP <= counter value at t;
  - THRESHOLD_WHEN_HIT / BASELINE_WHEN_HIT <= shadow values;
  - FRAME_COUNT += 1;
  - length counter <= 1.
- TRIG: TRIGGERED=1. Each DIN_VALID cycle:
  - no hit -> HOLDOFF;
  - length counter == MAX_TRIG_LEN (nonzero) -> HOLDOFF (forced end, even if hit persists);
  - otherwise length counter += 1, saturating.
  - DIN_VALID=0 cycles hold state and counters. ENABLE is ignored in TRIG.
- HOLDOFF: TRIGGERED=0. Counter loads eff = max(HOLDOFF_LEN, DELAY+2), computed at HOLDOFF_WIDTH+1 bits, and decrements every clock.
  - At 1: -> ARMED if ENABLE, else IDLE.
  - ENABLE=0 during HOLDOFF does not shorten it.
  - Guarantees the framer's footer (emitted DELAY+2 cycles after TRIGGERED falls) precedes the next header.
- Snapshots: held until the next trigger start.
- ARMED output: combinational decode of state.
- Reset mid-frame: TRIGGERED drops immediately (asynchronous); no footer is guaranteed.

Test Plan:
- Reset, ENABLE=1, BASELINE=100, THRESHOLD=50, lane3 sample 150 on one valid cycle at timestamp 20 -> TRIGGERED high 1 cycle later, TIME_STAMP=20, THRESHOLD_WHEN_HIT=50, BASELINE_WHEN_HIT=100, FRAME_COUNT=1.
- Samples 149 on all lanes -> no trigger. Sample 150 -> trigger (>= boundary). BASELINE=4095, THRESHOLD=4095 -> never triggers (no wrap).
- MAX_TRIG_LEN=4, hit held continuously -> TRIGGERED exactly 4 valid cycles, then HOLDOFF. Interleave DIN_VALID=0 gaps -> still 4 valid cycles.
- DELAY_CFG=6, HOLDOFF_LEN=2 -> re-arm after 8 cycles. HOLDOFF_LEN=20 -> re-arm after 20 cycles. A hit during holdoff is ignored.
- ENABLE dropped mid-TRIG -> frame completes, holdoff completes, then IDLE. THRESHOLD changed mid-TRIG -> snapshot and level unchanged until the next ARMED cycle.
- Assert RESETN=0 asynchronously while TRIGGERED=1 -> TRIGGERED and all outputs 0 before the next clock edge. Timestamp restarts at 0.
